conv_3x3_window_ctrl: RTL
=========================

Name: conv_3x3_window_ctrl

Overview:
Streaming sequencer that feeds the 3x3 8-channel convolution datapath. It accepts a raster-order 8-bit pixel stream for one frame and builds each 3x3 window using two line buffers and a 3x3 shift window. It presents each window as a packed 72-bit word, ordered as the convolution datapath expects, behind a valid/ready handshake. It sits between the frame source and the convolution datapath, and it sequences frames with start/busy/done.

Parameters:
IMG_W, 8, frame width in pixels (>=3)
IMG_H, 8, frame height in lines (>=3)

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse, begins a frame; ignored unless idle
pix_valid  in  1  input pixel valid
pix_ready  out  1  input pixel accepted when pix_valid & pix_ready
pix_data  in  8  input pixel, raster order, row 0 col 0 first
win_valid  out  1  window output valid
win_ready  in  1  downstream (datapath/result capture) accepts window
win_pixels  out  72  packed window; byte k = pixel at window row k/3, col k%3 (bits 7:0 = top-left, 71:64 = bottom-right)
win_row  out  $clog2(IMG_H)  top-left row of current window
win_col  out  $clog2(IMG_W)  top-left column of current window
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset values: pix_ready=0, win_valid=0, win_pixels=0, win_row=0, win_col=0, busy=0, done=0, FSM=IDLE, all counters 0. Line-buffer contents are don't-care.
- Async reset asserted mid-frame aborts the frame immediately. No done pulse is produced. The next frame requires a new start.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE -> STREAM on start. busy rises the next cycle.
  - STREAM -> DRAIN on acceptance of the final pixel (row IMG_H-1, col IMG_W-1).
  - DRAIN -> IDLE once no window is pending, i.e. win_valid=0 or win_ready=1 in that cycle. done=1 for exactly one cycle on that transition; busy falls in the same cycle.
- pix_ready = (state==STREAM) & (!win_valid | win_ready). It is combinational from state and the output register.
- On each accepted pixel:
  - col counter increments and wraps at IMG_W-1 to 0; row counter then increments.
  - The line buffers are read at col before being written at col. Line buffer 1 shifts into line buffer 0.
  - The shift window moves left by one column. Its new right column is {lb0[col], lb1[col], pix_data} for rows 0..2.
- Window emission is valid-only convolution, with no padding. An accepted pixel at row>=2 and col>=2 produces a window, registered one cycle after acceptance: win_valid=1, win_row=row-2, win_col=col-2.
- The shift window is reset at each new line. Windows from cols 0..1 of a line are never emitted, so the first window of each line contains no stale pixels.
- Windows emitted per frame = (IMG_H-2)*(IMG_W-2).
- Output hold: while win_valid & !win_ready, win_pixels/win_row/win_col are stable and pix_ready=0.
- Simultaneous win_ready and a new window-producing pixel in the same cycle: the old window is consumed and the new one loads with no bubble. Sustained throughput is 1 pixel/cycle.
- pix_valid while not in STREAM is ignored (pix_ready=0). start in STREAM/DRAIN is ignored.
- Counter widths: $clog2 of the dimension. There is no overflow beyond IMG_W-1/IMG_H-1.

Optional Feature:
Macro CONV_STRIDE2_EN.
- Defined: windows are emitted only when (row-2) and (col-2) are both even. This gives ceil((IMG_H-2)/2)*ceil((IMG_W-2)/2) windows per frame. Pixel acceptance, line buffering and done timing are unchanged.
- Undefined: stride 1 as described in Behaviour.

Test Plan:
1. IMG_W=IMG_H=4; start, then stream pixels 0..15 with win_ready=1 -> 4 windows.
   - First: row/col 0/0, bytes 0,1,2,4,5,6,8,9,10.
   - Last: 1/1, bytes 5,6,7,9,10,11,13,14,15.
   - done pulses once, 1 cycle after final pixel.
2. Same frame with win_ready held 0 after the first window for 5 cycles -> pix_ready=0 for those 5 cycles, win_pixels stable, no pixel lost, identical window sequence.
3. IMG_W=IMG_H=8, random pix_valid gaps and random win_ready -> 36 windows match the software 3x3 extraction, in raster order of (win_row, win_col).
4. Assert rst_n low after pixel 20 of an 8x8 frame -> all outputs return to reset values immediately, no done. A new start plus a full frame gives correct 36 windows.
5. start pulsed during STREAM and pix_valid driven in IDLE -> no effect: pix_ready=0 in IDLE, window count unchanged.
6. CONV_STRIDE2_EN defined, 8x8 frame, pixels 0..63 -> 9 windows at (0,0),(0,2),...,(4,4). Window (2,4) bytes = 20,21,22,28,29,30,36,37,38.

Source files
------------

// File: rtl/conv_3x3_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module : conv_3x3_window_ctrl
// Builds 3x3 windows from a raster pixel stream using two line buffers and a
// 3x3 shift window. Optional macro CONV_STRIDE2_EN emits stride-2 windows only.
// Rev    : 1.0
// ============================================================================
module conv_3x3_window_ctrl #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     pix_valid,
  output logic                     pix_ready,
  input  logic [7:0]               pix_data,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [71:0]              win_pixels,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] C_ROW_LAST = RW'(IMG_H - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    lb0_q [IMG_W];
  logic [7:0]    lb0_d [IMG_W];
  logic [7:0]    lb1_q [IMG_W];
  logic [7:0]    lb1_d [IMG_W];
  logic [7:0]    sw_q [3][3];
  logic [7:0]    sw_d [3][3];
  logic          win_valid_q, win_valid_d;
  logic [71:0]   win_pixels_q, win_pixels_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;

  logic       accept;
  logic       emit;
  logic       last_pix;
  logic       drain_exit;
  logic [7:0] new_col [3];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_STREAM;
      S_STREAM: if (accept && last_pix) state_d = S_DRAIN;
      S_DRAIN:  if (drain_exit) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    drain_exit = !win_valid_q || win_ready;
    pix_ready  = (state_q == S_STREAM) && (!win_valid_q || win_ready);
    done       = (state_q == S_DRAIN) && drain_exit;
    busy       = (state_q == S_STREAM) || ((state_q == S_DRAIN) && !drain_exit);
  end

  assign accept   = pix_valid && pix_ready;
  assign last_pix = (col_q == C_COL_LAST) && (row_q == C_ROW_LAST);

  // Column entering the window: row-2 from lb0, row-1 from lb1, current pixel.
  always_comb begin
    new_col[0] = lb0_q[col_q];
    new_col[1] = lb1_q[col_q];
    new_col[2] = pix_data;
  end

`ifdef CONV_STRIDE2_EN
  assign emit = accept && (row_q >= RW'(2)) && (col_q >= CW'(2)) && !row_q[0] && !col_q[0];
`else
  assign emit = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
`endif

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (state_q == S_IDLE && start) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_q == C_COL_LAST) begin
        col_d = '0;
        row_d = (row_q == C_ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_comb begin
    lb0_d = lb0_q;
    lb1_d = lb1_q;
    sw_d  = sw_q;
    if (accept) begin
      lb0_d[col_q] = lb1_q[col_q];
      lb1_d[col_q] = pix_data;
      for (int r = 0; r < 3; r++) begin
        // A new line starts with a clean window; its first two columns are never emitted.
        sw_d[r][0] = (col_q == '0) ? 8'h00 : sw_q[r][1];
        sw_d[r][1] = (col_q == '0) ? 8'h00 : sw_q[r][2];
        sw_d[r][2] = new_col[r];
      end
    end
  end

  always_comb begin
    win_valid_d  = win_valid_q;
    win_pixels_d = win_pixels_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    if (win_ready) win_valid_d = 1'b0;
    if (emit) begin
      win_valid_d  = 1'b1;
      win_pixels_d = {new_col[2], sw_q[2][2], sw_q[2][1],
                      new_col[1], sw_q[1][2], sw_q[1][1],
                      new_col[0], sw_q[0][2], sw_q[0][1]};
      win_row_d    = row_q - RW'(2);
      win_col_d    = col_q - CW'(2);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      sw_q         <= '{default: '{default: 8'h00}};
      win_valid_q  <= 1'b0;
      win_pixels_q <= '0;
      win_row_q    <= '0;
      win_col_q    <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      sw_q         <= sw_d;
      win_valid_q  <= win_valid_d;
      win_pixels_q <= win_pixels_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
    end
  end

  // Line buffer contents need no reset.
  always_ff @(posedge clk) begin
    lb0_q <= lb0_d;
    lb1_q <= lb1_d;
  end

  assign win_valid  = win_valid_q;
  assign win_pixels = win_pixels_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;

endmodule
`default_nettype wire
